pkt_router: RTL and testbench

- Routes each incoming multicast packet to exactly one of NUM_CHANNELS output channels.
- Routing uses a NUM_RREGS-entry key/mask/route table supplied by the register bank.
- Drops packets that match no table entry.
- Drops packets whose destination channel stays not-ready past a programmable wait.
- Sits between the packet assembler and the per-channel output links.

---
 rtl/pkt_router_pkg.sv | 17 +
 rtl/pkt_router_lookup.sv | 28 ++
 rtl/pkt_router.sv | 132 +++++++++++++
 tb/tb_pkt_router.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_router_pkg.sv
// Shared defaults and types for the packet router and its lookup table.
package pkt_router_pkg;

  localparam int PACKET_BITS  = 72;
  localparam int KEY_LSB      = 8;
  localparam int NUM_CHANNELS = 8;
  localparam int NUM_RREGS    = 16;
  localparam int ROUTE_BITS   = $clog2(NUM_CHANNELS);

  typedef logic [31:0]           key_t;
  typedef logic [ROUTE_BITS-1:0] route_t;

  // Bit positions inside rt_cnt_out
  localparam int RT_CNT_SENT = 0;
  localparam int RT_CNT_DROP = 1;

endpackage

// File: rtl/pkt_router_lookup.sv
// Combinational priority match of a packet key against the key/mask/route table.
module pkt_router_lookup
  import pkt_router_pkg::*;
#(
  parameter int NUM_RREGS = 16,
  parameter int RB        = 3
) (
  input  key_t                         key,
  input  logic [NUM_RREGS-1:0][31:0]   tbl_key,
  input  logic [NUM_RREGS-1:0][31:0]   tbl_mask,
  input  logic [NUM_RREGS-1:0][RB-1:0] tbl_route,
  output logic                         hit,
  output logic [RB-1:0]                route
);

  // Scan from the top so the lowest matching index is written last and wins.
  always_comb begin
    hit   = 1'b0;
    route = '0;
    for (int i = NUM_RREGS - 1; i >= 0; i--) begin
      if ((key & tbl_mask[i]) == tbl_key[i]) begin
        hit   = 1'b1;
        route = tbl_route[i];
      end
    end
  end

endmodule

// File: rtl/pkt_router.sv
// Two-stage multicast packet router with table lookup and output-wait drop timer.
// PKT_ROUTER_DROP_EN enables the timeout drop; without it S2 holds until accepted.
module pkt_router
  import pkt_router_pkg::*;
#(
  parameter int PACKET_BITS  = pkt_router_pkg::PACKET_BITS,
  parameter int NUM_RREGS    = pkt_router_pkg::NUM_RREGS,
  parameter int KEY_LSB      = pkt_router_pkg::KEY_LSB,
  parameter int NUM_CHANNELS = pkt_router_pkg::NUM_CHANNELS,
  localparam int RB          = $clog2(NUM_CHANNELS)
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [31:0]                              drop_wait_in,
  input  logic [NUM_RREGS-1:0][31:0]               reg_key_in,
  input  logic [NUM_RREGS-1:0][31:0]               reg_mask_in,
  input  logic [NUM_RREGS-1:0][RB-1:0]             reg_route_in,
  input  logic [PACKET_BITS-1:0]                   pkt_in_data_in,
  input  logic                                     pkt_in_vld_in,
  output logic                                     pkt_in_rdy_out,
  output logic [NUM_CHANNELS-1:0][PACKET_BITS-1:0] pkt_out_data_out,
  output logic [NUM_CHANNELS-1:0]                  pkt_out_vld_out,
  input  logic [NUM_CHANNELS-1:0]                  pkt_out_rdy_in,
  output logic [1:0]                               rt_cnt_out
);

  logic                   s1_vld, s1_hit, s2_vld, s2_hit;
  logic [PACKET_BITS-1:0] s1_data, s2_data;
  logic [RB-1:0]          s1_route, s2_route;
  logic                   lk_hit;
  logic [RB-1:0]          lk_route;
  key_t                   key;
  logic                   s2_rdy, s2_sent, s2_timeout, s2_drop, s2_done;
  logic                   s1_adv, in_xfer;

  assign key = pkt_in_data_in[KEY_LSB +: 32];

  pkt_router_lookup #(
    .NUM_RREGS (NUM_RREGS),
    .RB        (RB)
  ) u_lookup (
    .key       (key),
    .tbl_key   (reg_key_in),
    .tbl_mask  (reg_mask_in),
    .tbl_route (reg_route_in),
    .hit       (lk_hit),
    .route     (lk_route)
  );

  assign s2_rdy  = pkt_out_rdy_in[s2_route];
  assign s2_sent = s2_vld && s2_hit && s2_rdy;

`ifdef PKT_ROUTER_DROP_EN
  logic [31:0] wait_cnt;
  logic        s2_stall;

  assign s2_stall   = s2_vld && s2_hit && !s2_rdy;
  assign s2_timeout = s2_stall && (wait_cnt == drop_wait_in);

  // Cleared on every S2 load, so a timeout (which also advances S1) restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (s1_adv) begin
      wait_cnt <= '0;
    end else if (s2_stall) begin
      wait_cnt <= wait_cnt + 32'd1;
    end
  end
`else
  logic unused_drop_wait;

  assign s2_timeout       = 1'b0;
  assign unused_drop_wait = ^drop_wait_in;
`endif

  assign s2_drop        = (s2_vld && !s2_hit) || s2_timeout;
  assign s2_done        = s2_sent || s2_drop;
  assign s1_adv         = !s2_vld || s2_done;
  assign pkt_in_rdy_out = !s1_vld || s1_adv;
  assign in_xfer        = pkt_in_vld_in && pkt_in_rdy_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld   <= 1'b0;
      s1_hit   <= 1'b0;
      s1_route <= '0;
      s1_data  <= '0;
    end else if (in_xfer) begin
      s1_vld   <= 1'b1;
      s1_hit   <= lk_hit;
      s1_route <= lk_route;
      s1_data  <= pkt_in_data_in;
    end else if (s1_adv) begin
      s1_vld   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_vld   <= 1'b0;
      s2_hit   <= 1'b0;
      s2_route <= '0;
      s2_data  <= '0;
    end else if (s1_adv) begin
      s2_vld   <= s1_vld;
      s2_hit   <= s1_hit;
      s2_route <= s1_route;
      s2_data  <= s1_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rt_cnt_out <= '0;
    end else begin
      rt_cnt_out[RT_CNT_SENT] <= s2_sent;
      rt_cnt_out[RT_CNT_DROP] <= s2_drop;
    end
  end

  // Every channel sees the S2 packet; only the routed channel gets valid.
  always_comb begin
    pkt_out_vld_out  = '0;
    pkt_out_data_out = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      pkt_out_vld_out[c]  = s2_vld && s2_hit && (s2_route == RB'(c));
      pkt_out_data_out[c] = s2_data;
    end
  end

endmodule

// File: tb/tb_pkt_router.sv
// Scoreboard bench for pkt_router: routing, drops, priority, stalls and reset.
module tb_pkt_router;
  import pkt_router_pkg::*;

  localparam int NR = 16;
  localparam int NC = 8;
  localparam int PB = 72;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [31:0]           drop_wait_in = 32'd4;
  logic [NR-1:0][31:0]   reg_key_in;
  logic [NR-1:0][31:0]   reg_mask_in;
  logic [NR-1:0][2:0]    reg_route_in;
  logic [PB-1:0]         pkt_in_data_in = '0;
  logic                  pkt_in_vld_in = 1'b0;
  logic                  pkt_in_rdy_out;
  logic [NC-1:0][PB-1:0] pkt_out_data_out;
  logic [NC-1:0]         pkt_out_vld_out;
  logic [NC-1:0]         pkt_out_rdy_in = '1;
  logic [1:0]            rt_cnt_out;

  typedef struct {
    int            ch;
    logic [PB-1:0] data;
  } exp_t;

  exp_t sb[$];
  int tests = 0, fails = 0;
  int sent_cnt = 0, drop_cnt = 0, stall_cnt = 0, hold_cycles = 0;
  logic          rdy_toggle = 1'b0;
  logic [NC-1:0] rdy_static = '1;

  always #5 clk = ~clk;

  pkt_router dut (
    .clk              (clk),
    .reset            (reset),
    .drop_wait_in     (drop_wait_in),
    .reg_key_in       (reg_key_in),
    .reg_mask_in      (reg_mask_in),
    .reg_route_in     (reg_route_in),
    .pkt_in_data_in   (pkt_in_data_in),
    .pkt_in_vld_in    (pkt_in_vld_in),
    .pkt_in_rdy_out   (pkt_in_rdy_out),
    .pkt_out_data_out (pkt_out_data_out),
    .pkt_out_vld_out  (pkt_out_vld_out),
    .pkt_out_rdy_in   (pkt_out_rdy_in),
    .rt_cnt_out       (rt_cnt_out)
  );

  always @(negedge clk) begin
    if (rdy_toggle) pkt_out_rdy_in = ~pkt_out_rdy_in;
    else            pkt_out_rdy_in = rdy_static;
  end

  // Output monitor: pops the scoreboard on every output transfer.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (reset) begin
      if (pkt_out_vld_out != '0) begin
        tests++;
        if ($countones(pkt_out_vld_out) != 1) begin
          fails++;
          $display("FAIL onehot vld=%b required exactly one bit", pkt_out_vld_out);
        end
      end
      if (pkt_out_vld_out[3]) hold_cycles++;
      for (int c = 0; c < NC; c++) begin
        if (pkt_out_vld_out[c] && pkt_out_rdy_in[c]) begin
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pkt ch=%0d data=%h required none", c, pkt_out_data_out[c]);
          end else begin
            e = sb.pop_front();
            if (e.ch != c || e.data !== pkt_out_data_out[c]) begin
              fails++;
              $display("FAIL sb_pkt got ch=%0d data=%h required ch=%0d data=%h",
                       c, pkt_out_data_out[c], e.ch, e.data);
            end
          end
        end
      end
      if (rt_cnt_out[0]) sent_cnt++;
      if (rt_cnt_out[1]) drop_cnt++;
      if (rt_cnt_out == 2'b11) begin
        tests++;
        fails++;
        $display("FAIL strobe_excl rt_cnt=%b required not 11", rt_cnt_out);
      end
    end
  end

  function automatic void model(input logic [31:0] k, output logic hit, output int ch);
    hit = 1'b0;
    ch  = 0;
    for (int i = 0; i < NR; i++) begin
      if (!hit && ((k & reg_mask_in[i]) == reg_key_in[i])) begin
        hit = 1'b1;
        ch  = int'(reg_route_in[i]);
      end
    end
  endfunction

  task automatic set_mod_table();
    for (int i = 0; i < NR; i++) begin
      reg_key_in[i]   = i;
      reg_mask_in[i]  = 32'h1F;
      reg_route_in[i] = 3'(i & 7);
    end
  endtask

  // Called in the low phase; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] k, input bit deliver);
    logic [PB-1:0] d;
    logic          h;
    int            ch;
    bit            ok;
    d = {$urandom(), k, 8'($urandom())};
    pkt_in_data_in = d;
    pkt_in_vld_in  = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      #1;
      ok = pkt_in_rdy_out;
      @(posedge clk);
      if (!ok) begin
        stall_cnt++;
        @(negedge clk);
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout key=%h rdy=%b required 1", k, pkt_in_rdy_out);
    end else begin
      model(k, h, ch);
      if (h && deliver) sb.push_back('{ch, d});
    end
    @(negedge clk);
    pkt_in_vld_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    set_mod_table();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (pkt_out_vld_out !== '0) begin
      fails++; $display("FAIL rst_vld got=%b required 0", pkt_out_vld_out);
    end
    tests++;
    if (rt_cnt_out !== 2'b00) begin
      fails++; $display("FAIL rst_cnt got=%b required 00", rt_cnt_out);
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    tests++;
    if (pkt_in_rdy_out !== 1'b1) begin
      fails++; $display("FAIL rst_rdy got=%b required 1", pkt_in_rdy_out);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int s0 = sent_cnt, st0 = stall_cnt;
    set_mod_table();
    rdy_static = '1;
    for (int k = 0; k < 16; k++) send(k, 1'b1);
    drain();
    tests++;
    if (sent_cnt - s0 != 16) begin
      fails++; $display("FAIL b2b_sent got=%0d required 16", sent_cnt - s0);
    end
    tests++;
    if (stall_cnt - st0 != 0) begin
      fails++; $display("FAIL b2b_stall got=%0d required 0", stall_cnt - st0);
    end
  endtask

  task automatic test_unroutable();
    int s0 = sent_cnt, d0 = drop_cnt, st0 = stall_cnt;
    for (int k = 16; k < 32; k++) send(k, 1'b1);
    drain();
    tests++;
    if (drop_cnt - d0 != 16) begin
      fails++; $display("FAIL unr_drop got=%0d required 16", drop_cnt - d0);
    end
    tests++;
    if (sent_cnt - s0 != 0) begin
      fails++; $display("FAIL unr_sent got=%0d required 0", sent_cnt - s0);
    end
    tests++;
    if (stall_cnt - st0 != 0) begin
      fails++; $display("FAIL unr_stall got=%0d required 0", stall_cnt - st0);
    end
  endtask

  task automatic test_priority();
    for (int i = 0; i < NR; i++) begin
      reg_key_in[i]   = 32'hFFFF_0000 | i;
      reg_mask_in[i]  = 32'hFFFF_FFFF;
      reg_route_in[i] = 3'd0;
    end
    reg_key_in[2] = 32'h25; reg_mask_in[2] = 32'hFF; reg_route_in[2] = 3'd6;
    reg_key_in[5] = 32'h25; reg_mask_in[5] = 32'hFF; reg_route_in[5] = 3'd1;
    send(32'h25, 1'b1);
    #3;
    tests++;
    if (pkt_out_vld_out !== 8'h00) begin
      fails++; $display("FAIL lat_early vld=%b required 00000000", pkt_out_vld_out);
    end
    @(negedge clk);
    #3;
    tests++;
    if (pkt_out_vld_out !== 8'h40) begin
      fails++; $display("FAIL lat_prio vld=%b required 01000000", pkt_out_vld_out);
    end
    drain();
    reg_mask_in[2] = 32'hFFF;
    send(32'h125, 1'b1);
    drain();
  endtask

  task automatic test_drop();
    int d0;
    set_mod_table();
    drop_wait_in = 32'd4;
    rdy_static   = 8'hF7;
    repeat (2) @(negedge clk);
    d0 = drop_cnt;
    hold_cycles = 0;
    send(3, 1'b0);
    send(1, 1'b1);
    #1;
    tests++;
    if (pkt_in_rdy_out !== 1'b0) begin
      fails++; $display("FAIL full_rdy got=%b required 0", pkt_in_rdy_out);
    end
`ifdef PKT_ROUTER_DROP_EN
    send(2, 1'b1);
    drain();
    tests++;
    if (hold_cycles != 5) begin
      fails++; $display("FAIL drop_hold got=%0d required 5", hold_cycles);
    end
    tests++;
    if (drop_cnt - d0 != 1) begin
      fails++; $display("FAIL drop_cnt got=%0d required 1", drop_cnt - d0);
    end
`else
    repeat (10) @(negedge clk);
    #3;
    tests++;
    if (pkt_out_vld_out !== 8'h08) begin
      fails++; $display("FAIL hold_vld got=%b required 00001000", pkt_out_vld_out);
    end
    sb.push_front('{3, pkt_out_data_out[3]});
    rdy_static = '1;
    @(negedge clk);
    send(2, 1'b1);
    drain();
    tests++;
    if (drop_cnt - d0 != 0) begin
      fails++; $display("FAIL hold_drop got=%0d required 0", drop_cnt - d0);
    end
`endif
    rdy_static = '1;
    @(negedge clk);
  endtask

  task automatic test_rdy_toggle();
    int s0 = sent_cnt, d0 = drop_cnt;
    set_mod_table();
    drop_wait_in = 32'd4;
    rdy_toggle = 1'b1;
    for (int k = 15; k >= 0; k--) send(k, 1'b1);
    drain();
    rdy_toggle = 1'b0;
    @(negedge clk);
    tests++;
    if (sent_cnt - s0 != 16) begin
      fails++; $display("FAIL tog_sent got=%0d required 16", sent_cnt - s0);
    end
    tests++;
    if (drop_cnt - d0 != 0) begin
      fails++; $display("FAIL tog_drop got=%0d required 0", drop_cnt - d0);
    end
  endtask

  task automatic test_reset_midstream();
    int s0, d0;
    set_mod_table();
    rdy_static = 8'hF7;
    repeat (2) @(negedge clk);
    send(3, 1'b0);
    @(negedge clk);
    #1;
    tests++;
    if (pkt_out_vld_out[3] !== 1'b1) begin
      fails++; $display("FAIL mid_hold got=%b required 1", pkt_out_vld_out[3]);
    end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (pkt_out_vld_out !== '0) begin
      fails++; $display("FAIL mid_rst_vld got=%b required 0", pkt_out_vld_out);
    end
    tests++;
    if (pkt_in_rdy_out !== 1'b1) begin
      fails++; $display("FAIL mid_rst_rdy got=%b required 1", pkt_in_rdy_out);
    end
    @(negedge clk);
    reset = 1'b1;
    rdy_static = '1;
    s0 = sent_cnt;
    d0 = drop_cnt;
    repeat (2) @(negedge clk);
    send(5, 1'b1);
    drain();
    tests++;
    if (sent_cnt - s0 != 1 || drop_cnt - d0 != 0) begin
      fails++;
      $display("FAIL mid_after sent=%0d drop=%0d required 1 0", sent_cnt - s0, drop_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_unroutable();
    test_priority();
    test_drop();
    test_rdy_toggle();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
